// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory access sequencer for a 5-stage RISC-V
// pipeline. Issues one request/acknowledge bus transaction per load or store,
// stalls the pipeline until the bus acknowledges, captures load data, and
// reports misaligned or timed-out accesses as a one-cycle fault pulse.
//
// Optional build macro: MEM_ACCESS_STATS_EN adds the stat_accesses and
// stat_stall_cycles counters and ports.
//
// Parameters: ADDR_W/DATA_W size the bus; TIMEOUT (2..255) is the maximum
// number of REQ cycles spent waiting for bus_ack before the access faults.

module mem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWriteM,
  input  logic [1:0]        ResultSrcM,
  input  logic [31:0]       AluResultM,
  input  logic [31:0]       WriteDataM,
  output logic              StallM,
  output logic [31:0]       ReadDataM,
  output logic              AccessFaultM,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [31:0]       stat_accesses,
  output logic [31:0]       stat_stall_cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_DONE = 2'b10,
    S_ERR  = 2'b11
  } state_t;

  // Last counter value allowed in REQ; reaching it without an ack aborts.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_access;
  logic                w_aligned;
  logic                w_stall;
  logic [7:0]          r_cnt;
  logic                r_bus_req;
  logic                r_bus_we;
  logic [ADDR_W-1:0]   r_bus_addr;
  logic [DATA_W-1:0]   r_bus_wdata;
  logic [31:0]         r_rdata;
  logic                r_fault;

  assign w_access  = MemWriteM | (ResultSrcM == 2'b01);
  assign w_aligned = (AluResultM[1:0] == 2'b00);

  // Stall while the access is still pending; gated by reset so an
  // asynchronous reset releases the pipeline before the next clock edge.
  assign w_stall = reset & w_access & ((r_state == S_IDLE) | (r_state == S_REQ));

  assign StallM       = w_stall;
  assign ReadDataM    = r_rdata;
  assign AccessFaultM = r_fault;
  assign bus_req      = r_bus_req;
  assign bus_we       = r_bus_we;
  assign bus_addr     = r_bus_addr;
  assign bus_wdata    = r_bus_wdata;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          if (w_aligned) begin
            w_state_nxt = S_REQ;
          end else begin
            w_state_nxt = S_ERR;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        if (bus_ack) begin
          w_state_nxt = S_DONE;
        end else if (r_cnt == TMO_LAST) begin
          w_state_nxt = S_ERR;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs, fault pulse and wait counter, all registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_fault     <= 1'b0;
      r_cnt       <= 8'd0;
    end else begin
      r_bus_req <= (w_state_nxt == S_REQ);
      r_fault   <= (w_state_nxt == S_ERR);
      if ((r_state == S_IDLE) && (w_state_nxt == S_REQ)) begin
        r_bus_we    <= MemWriteM;
        r_bus_addr  <= ADDR_W'(AluResultM);
        r_bus_wdata <= DATA_W'(WriteDataM);
        r_cnt       <= 8'd0;
      end else if ((r_state == S_REQ) && (w_state_nxt == S_REQ)) begin
        r_cnt <= r_cnt + 8'd1;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // Load data capture: only a completing load updates ReadDataM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= 32'd0;
    end else if ((r_state == S_REQ) && bus_ack && !r_bus_we) begin
      r_rdata <= 32'(bus_rdata);
    end else begin
      r_rdata <= r_rdata;
    end
  end

`ifdef MEM_ACCESS_STATS_EN
  logic [31:0] r_stat_acc;
  logic [31:0] r_stat_stall;

  assign stat_accesses     = r_stat_acc;
  assign stat_stall_cycles = r_stat_stall;

  // Saturating counters of completed accesses and stalled cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_acc   <= 32'd0;
      r_stat_stall <= 32'd0;
    end else begin
      if ((r_state == S_DONE) && (r_stat_acc != 32'hFFFF_FFFF)) begin
        r_stat_acc <= r_stat_acc + 32'd1;
      end else begin
        r_stat_acc <= r_stat_acc;
      end
      if (w_stall && (r_stat_stall != 32'hFFFF_FFFF)) begin
        r_stat_stall <= r_stat_stall + 32'd1;
      end else begin
        r_stat_stall <= r_stat_stall;
      end
    end
  end
`endif

endmodule
